// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared widths and issue-FSM encoding for the multiplier feeder
package mul_pkg;

   localparam int N_BITS_DEF = 4;
   localparam int PROD_W_DEF = 2 * N_BITS_DEF;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      START   = 2'd1,
      WAIT_LO = 2'd2,
      WAIT_HI = 2'd3
   } feed_state_t;

endpackage

// File: rtl/mul.sv
// rtl/mul.sv - iterative shift-add multiplier with start/done handshake
module mul
   import mul_pkg::*;
#(
   parameter int N_BITS = N_BITS_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [N_BITS-1:0]     m,
   input  logic [N_BITS-1:0]     r,
   output logic                  done,
   output logic [2*N_BITS-1:0]   prod
);

   logic [2*N_BITS-1:0] a;
   logic [N_BITS-1:0]   b;

   // One multiplier bit per cycle; stop when the remaining multiplier is zero so
   // the busy time is bitlen(r)+1. prod doubles as the accumulator and is stable while done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done <= 1'b1;
         prod <= '0;
         a    <= '0;
         b    <= '0;
      end else if (done) begin
         if (start) begin
            done <= 1'b0;
            prod <= '0;
            a    <= {{N_BITS{1'b0}}, m};
            b    <= r;
         end
      end else if (b == '0) begin
         done <= 1'b1;
      end else begin
         if (b[0]) prod <= prod + a;
         a <= a << 1;
         b <= b >> 1;
      end
   end

endmodule

// File: rtl/mul_op_fifo.sv
// rtl/mul_op_fifo.sv - synchronous operand FIFO with combinational head
module mul_op_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   // Extra pointer MSB distinguishes full from empty when the indices match.
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dout  = mem[rd_ptr[AW-1:0]];

   // Pointer update; push and pop in one cycle both advance, leaving the count unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage write; contents need no reset because empty masks them.
   always_ff @(posedge clk) begin
      if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/mul_feeder.sv
// rtl/mul_feeder.sv - queues operand pairs, issues them to mul, buffers the product
module mul_feeder
   import mul_pkg::*;
#(
   parameter int N_BITS = N_BITS_DEF,
   parameter int DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [N_BITS-1:0]     in_m,
   input  logic [N_BITS-1:0]     in_r,
   output logic                  mul_start,
   output logic [N_BITS-1:0]     mul_m,
   output logic [N_BITS-1:0]     mul_r,
   input  logic                  mul_done,
   input  logic [2*N_BITS-1:0]   mul_prod,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [2*N_BITS-1:0]   out_prod,
   output logic                  busy
);

   feed_state_t           state;
   feed_state_t           state_nxt;
   logic                  pop;
   logic                  capture;
   logic                  full;
   logic                  empty;
   logic [2*N_BITS-1:0]   head;

   assign in_ready = !full;
   assign busy     = !empty || (state != IDLE) || out_valid;

   mul_op_fifo #(
      .WIDTH (2*N_BITS),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_valid && !full),
      .pop   (pop),
      .din   ({in_m, in_r}),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

   // Issue FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state and Moore outputs; capture waits for a free result slot so mul holds prod.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      capture   = 1'b0;
      mul_start = 1'b0;
      case (state)
         IDLE: begin
            if (!empty && mul_done) begin
               state_nxt = START;
               pop       = 1'b1;
            end
         end
         START: begin
            mul_start = 1'b1;
            state_nxt = WAIT_LO;
         end
         WAIT_LO: begin
            if (!mul_done) state_nxt = WAIT_HI;
         end
         WAIT_HI: begin
            if (mul_done && (!out_valid || out_ready)) begin
               state_nxt = IDLE;
               capture   = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand registers load on pop and hold for the whole job.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mul_m <= '0;
         mul_r <= '0;
      end else if (pop) begin
         mul_m <= head[2*N_BITS-1:N_BITS];
         mul_r <= head[N_BITS-1:0];
      end
   end

   // Result register; a capture in the same cycle as out_ready keeps out_valid set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_prod  <= '0;
      end else if (capture) begin
         out_valid <= 1'b1;
         out_prod  <= mul_prod;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mul_feeder.sv
// tb/tb_mul_feeder.sv - directed bench for mul_feeder driving a real mul
module tb_mul_feeder;

   localparam int NB = 4;
   localparam int PW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [NB-1:0] in_m = '0;
   logic [NB-1:0] in_r = '0;
   logic          mul_start;
   logic [NB-1:0] mul_m;
   logic [NB-1:0] mul_r;
   logic          mul_done;
   logic [PW-1:0] mul_prod;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [PW-1:0] out_prod;
   logic          busy;

   int checks = 0;
   int errors = 0;
   logic [PW-1:0] got_q[$];
   int start_cnt = 0;

   typedef struct {
      logic [NB-1:0] m;
      logic [NB-1:0] r;
      logic [PW-1:0] prod;
      int            lat;
   } vec_t;

   vec_t vt[4];
   logic [NB-1:0] bm_q[$];
   logic [NB-1:0] br_q[$];
   logic [PW-1:0] be_q[$];

   mul_feeder #(.N_BITS(NB), .DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_m      (in_m),
      .in_r      (in_r),
      .mul_start (mul_start),
      .mul_m     (mul_m),
      .mul_r     (mul_r),
      .mul_done  (mul_done),
      .mul_prod  (mul_prod),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_prod  (out_prod),
      .busy      (busy)
   );

   mul #(.N_BITS(NB)) u_mul (
      .clk   (clk),
      .rst   (rst),
      .start (mul_start),
      .m     (mul_m),
      .r     (mul_r),
      .done  (mul_done),
      .prod  (mul_prod)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) got_q.push_back(out_prod);
         if (mul_start) start_cnt++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int t = 0;
      while (busy && t < 300) begin
         tick();
         t++;
      end
      chk("idle_before_test", {31'd0, busy}, 0);
   endtask

   task automatic single_job(input logic [NB-1:0] m, input logic [NB-1:0] r,
                             input logic [PW-1:0] exp_prod, input int exp_lat);
      int cyc;
      int st_cyc;
      int ov_cyc;
      logic [PW-1:0] got;
      out_ready = 1'b1;
      tick();
      in_m = m;
      in_r = r;
      in_valid = 1'b1;
      chk("in_ready_cycle0", {31'd0, in_ready}, 1);
      tick();
      in_valid = 1'b0;
      cyc = 1;
      st_cyc = -1;
      ov_cyc = -1;
      got = '0;
      while (cyc < 60 && ov_cyc < 0) begin
         if (mul_start && st_cyc < 0) st_cyc = cyc;
         if (out_valid) begin
            ov_cyc = cyc;
            got = out_prod;
         end else begin
            tick();
            cyc++;
         end
      end
      chk("start_cycle", st_cyc, 2);
      chk("out_valid_cycle", ov_cyc, exp_lat);
      chk("out_prod", {24'd0, got}, {24'd0, exp_prod});
   endtask

   task automatic push_queue();
      int t;
      in_valid = 1'b1;
      for (int i = 0; i < bm_q.size(); i++) begin
         in_m = bm_q[i];
         in_r = br_q[i];
         t = 0;
         while (!in_ready && t < 300) begin
            tick();
            t++;
         end
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic collect(input int base, input string name);
      int t = 0;
      while (got_q.size() < base + be_q.size() && t < 600) begin
         tick();
         t++;
      end
      repeat (4) tick();
      chk({name, "_count"}, got_q.size() - base, be_q.size());
      for (int i = 0; i < be_q.size(); i++) begin
         if (base + i < got_q.size())
            chk({name, "_result"}, {24'd0, got_q[base+i]}, {24'd0, be_q[i]});
      end
   endtask

   initial begin
      int base;
      int s0;
      int seen;
      int held_ok;
      int saw_full;
      int t;
      logic [PW-1:0] first;

      vt[0] = '{m: 4'd3,  r: 4'd5,  prod: 8'd15,  lat: 8};
      vt[1] = '{m: 4'd0,  r: 4'd9,  prod: 8'd0,   lat: 9};
      vt[2] = '{m: 4'd15, r: 4'd0,  prod: 8'd0,   lat: 5};
      vt[3] = '{m: 4'd15, r: 4'd15, prod: 8'd225, lat: 9};

      // reset state
      repeat (3) tick();
      chk("rst_out_valid", {31'd0, out_valid}, 0);
      chk("rst_mul_start", {31'd0, mul_start}, 0);
      chk("rst_mul_m", {28'd0, mul_m}, 0);
      chk("rst_mul_r", {28'd0, mul_r}, 0);
      chk("rst_out_prod", {24'd0, out_prod}, 0);
      rst = 1'b0;
      tick();
      chk("rel_in_ready", {31'd0, in_ready}, 1);
      chk("rel_busy", {31'd0, busy}, 0);

      // single jobs and zero/edge operands
      for (int i = 0; i < 4; i++) begin
         wait_idle();
         single_job(vt[i].m, vt[i].r, vt[i].prod, vt[i].lat);
      end

      // back-to-back burst of six
      wait_idle();
      bm_q.delete(); br_q.delete(); be_q.delete();
      for (int i = 1; i <= 6; i++) begin
         bm_q.push_back(4'(i));
         br_q.push_back(4'(i));
      end
      be_q = '{8'd1, 8'd4, 8'd9, 8'd16, 8'd25, 8'd36};
      base = got_q.size();
      saw_full = 0;
      fork
         push_queue();
         begin
            repeat (40) begin
               if (!in_ready) saw_full = 1;
               tick();
            end
         end
      join
      chk("burst_saw_full", saw_full, 1);
      collect(base, "burst");
      chk("burst_in_ready_back", {31'd0, in_ready}, 1);

      // backpressure on the result stream
      wait_idle();
      out_ready = 1'b0;
      s0 = start_cnt;
      base = got_q.size();
      bm_q = '{4'd2, 4'd5, 4'd9};
      br_q = '{4'd3, 4'd7, 4'd11};
      be_q = '{8'd6, 8'd35, 8'd99};
      push_queue();
      seen = 0;
      held_ok = 1;
      first = '0;
      repeat (40) begin
         tick();
         if (out_valid) begin
            if (seen == 0) begin
               seen = 1;
               first = out_prod;
            end else if (out_prod !== first) begin
               held_ok = 0;
            end
         end
      end
      chk("bp_seen_valid", seen, 1);
      chk("bp_first_prod", {24'd0, first}, 6);
      chk("bp_held_stable", held_ok, 1);
      chk("bp_start_count", start_cnt - s0, 2);
      out_ready = 1'b1;
      collect(base, "bp");

      // twelve jobs across three FIFO refills
      wait_idle();
      bm_q.delete(); br_q.delete(); be_q.delete();
      for (int i = 0; i < 12; i++) begin
         bm_q.push_back(4'((i * 7 + 3) % 16));
         br_q.push_back(4'((i * 5 + 1) % 16));
         be_q.push_back(8'(((i * 7 + 3) % 16) * ((i * 5 + 1) % 16)));
      end
      base = got_q.size();
      push_queue();
      collect(base, "wrap");

      // reset while waiting on mul with jobs queued
      wait_idle();
      bm_q = '{4'd1, 4'd2, 4'd3};
      br_q = '{4'd15, 4'd15, 4'd15};
      push_queue();
      repeat (3) tick();
      chk("pre_rst_busy", {31'd0, busy}, 1);
      chk("pre_rst_mul_done", {31'd0, mul_done}, 0);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", {31'd0, out_valid}, 0);
      chk("mid_rst_mul_start", {31'd0, mul_start}, 0);
      chk("mid_rst_mul_m", {28'd0, mul_m}, 0);
      chk("mid_rst_mul_r", {28'd0, mul_r}, 0);
      chk("mid_rst_out_prod", {24'd0, out_prod}, 0);
      chk("mid_rst_busy", {31'd0, busy}, 0);
      chk("mid_rst_in_ready", {31'd0, in_ready}, 1);
      repeat (2) tick();
      rst = 1'b0;
      tick();
      base = got_q.size();
      single_job(4'd2, 4'd7, 8'd14, 8);
      t = 0;
      repeat (30) tick();
      chk("post_rst_result_count", got_q.size() - base, 1);
      chk("post_rst_idle", {31'd0, busy}, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
